uart_rx_word: RTL and testbench
===============================

// Module: uart_rx_word
// PURPOSE
//  Parametrised multi-byte UART receiver. Has its own 16x oversampling tick generator.
//  Assembles NUM_BYTES consecutive 8N1 bytes into one word and presents it with a
//  1-cycle valid strobe. Detects false starts, framing errors and inter-byte timeouts.
//  Replaces the fixed-width receivers. Feeds any host-command or challenge register.
// PARAMETERS
//  CLKS_PER_SAMPLE  27  clk cycles per 1/16 bit period (>=2); bit time = 16*CLKS_PER_SAMPLE
//  NUM_BYTES        4   bytes per word (1..16); W = 8*NUM_BYTES
//  MSB_FIRST        1   1: first byte received -> data_o[W-1:W-8]; 0: first byte -> data_o[7:0]
//  TIMEOUT_BITS     20  idle bit times allowed between bytes of one word before discard
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-high reset
//  enable       in   1           receiver enable; low = hold FSM idle, clear partial word
//  rx           in   1           serial input, idle high, asynchronous to clk
//  data_o       out  W           last complete word; held until next complete word
//  valid_o      out  1           1-cycle pulse when data_o updates
//  frame_err_o  out  1           1-cycle pulse on a bad stop bit
//  timeout_o    out  1           1-cycle pulse when a partial word is discarded on timeout
//  byte_cnt_o   out  4           bytes of the current word received so far (0..NUM_BYTES-1)
//  busy_o       out  1           high from start-bit detect until stop-bit decision
// BEHAVIOUR
//  Reset values: data_o=0, valid_o=0, frame_err_o=0, timeout_o=0, byte_cnt_o=0, busy_o=0.
//  Reset also clears the FSM to IDLE. The rx 2-flop synchroniser resets to 1.
//  rx: 2-flop synchroniser. All decisions use the synchronised value (2-clk input latency).
//  Tick: a counter 0..CLKS_PER_SAMPLE-1 produces a 1-clk tick on wrap. It runs only while
//   enable=1. It is reset to 0 on start-bit detect so the sample phase is aligned.
//  Byte FSM (s = tick count within the bit, 0..15):
//   IDLE:  rx=0 -> START, s=0, busy_o=1.
//   START: at s=7, rx=1 -> IDLE (false start, no pulse); rx=0 -> DATA, bit=0, s=0.
//   DATA:  sample rx at s=15 (mid-bit). Shift LSB-first. After bit 7 is sampled -> STOP.
//   STOP:  sample at mid-bit.
//          rx=1: good byte -> IDLE.
//          rx=0: frame_err_o pulse; shadow word and byte_cnt_o -> 0; go to BREAK.
//   BREAK: wait for rx=1, then IDLE. A held-low line produces exactly one frame_err_o.
//   busy_o=0 in IDLE and BREAK.
//  Word assembly:
//   Each good byte is written into a shadow register at the slot set by byte_cnt_o and
//   MSB_FIRST, then byte_cnt_o increments.
//   On the good byte with byte_cnt_o=NUM_BYTES-1:
//    - data_o <= shadow with the final byte merged in;
//    - valid_o=1 for exactly one clk, on the clk after the stop-bit sample tick;
//    - byte_cnt_o -> 0.
//   data_o never shows a partial word.
//  Timeout: while IDLE and byte_cnt_o!=0, count ticks.
//   At TIMEOUT_BITS*16 ticks: timeout_o pulse, shadow and byte_cnt_o -> 0.
//   The counter clears on every start-bit detect.
//   If a start bit and the timeout occur on the same clk, the start bit wins (no timeout).
//  enable=0 (synchronous): FSM -> IDLE, byte_cnt_o -> 0, shadow cleared, tick held.
//   No pulses. data_o is retained. A byte in flight is dropped.
//  Pulse outputs are mutually exclusive on any clk.
//  Back-to-back bytes: a new start bit accepted immediately after the STOP mid-sample is
//   received correctly (no idle gap needed).
// TESTING  (CLKS_PER_SAMPLE=4, i.e. 64 clk/bit, NUM_BYTES=4, TIMEOUT_BITS=20 unless noted)
//  1. Send DE AD BE EF -> single valid_o pulse, data_o=32'hDEADBEEF.
//     With MSB_FIRST=0 the same bytes give 32'hEFBEADDE.
//  2. rx low glitch of 20 clk while idle -> no state change, byte_cnt_o=0, no pulses.
//  3. Send 11 22, then a third byte with stop=0 -> frame_err_o pulse, no valid_o,
//     byte_cnt_o=0. Then send 01 02 03 04 -> data_o=32'h01020304.
//  4. Send 2 bytes, then idle 21 bit times -> timeout_o pulse, byte_cnt_o=0.
//     Then send CA FE BA BE -> data_o=32'hCAFEBABE.
//  5. Assert reset mid-byte 3 -> all outputs 0 immediately.
//     Drop enable mid-word -> data_o retains the previous word, the next word is correct.
//  6. Send 3 words back-to-back with no idle gap -> exactly 3 valid_o pulses, each with
//     the correct value. Repeat with NUM_BYTES=1 and NUM_BYTES=16.

Source files
------------

// File: rtl/uart_rx_word.sv
// uart_rx_word
//   Multi-byte 8N1 UART receiver. It has its own 16x oversampling tick
//   generator and assembles NUM_BYTES consecutive bytes into one word. The
//   word is presented on data_o together with a one-cycle valid strobe. The
//   receiver also detects false starts, bad stop bits and idle gaps that are
//   too long between the bytes of one word.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       receiver enable; low holds the FSM idle and drops any partial word
//   rx           serial input, idle high, asynchronous to clk
//   data_o       last complete word (8*NUM_BYTES bits), held until the next one
//   valid_o      one-cycle pulse when data_o updates
//   frame_err_o  one-cycle pulse on a bad stop bit
//   timeout_o    one-cycle pulse when a partial word is discarded on timeout
//   byte_cnt_o   bytes of the current word received so far
//   busy_o       high from start-bit detect until the stop-bit decision
module uart_rx_word #(
  parameter int CLKS_PER_SAMPLE = 27,
  parameter int NUM_BYTES       = 4,
  parameter bit MSB_FIRST       = 1'b1,
  parameter int TIMEOUT_BITS    = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rx,
  output logic [8*NUM_BYTES-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic                   timeout_o,
  output logic [3:0]             byte_cnt_o,
  output logic                   busy_o
);

  localparam int W        = 8 * NUM_BYTES;
  localparam int TCW      = $clog2(CLKS_PER_SAMPLE);
  localparam int TO_TICKS = TIMEOUT_BITS * 16;
  localparam int TOW      = $clog2(TO_TICKS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [TCW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]      samp_q, samp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    data_q, data_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_q, timeout_d;

  logic            tick;
  logic [3:0]      slot;
  logic [W-1:0]    merged;

  // The tick counter stops while the receiver is disabled.
  assign tick = enable && (tick_cnt_q == TCW'(CLKS_PER_SAMPLE - 1));

  // Slot where the byte now in the shift register lands in the word.
  assign slot = MSB_FIRST ? (4'(NUM_BYTES - 1) - byte_cnt_q) : byte_cnt_q;

  always_comb begin
    merged = shadow_q;
    merged[int'(slot)*8 +: 8] = shift_q;
  end

  always_comb begin
    // NOTE: every variable gets a default value first. Paths that do not
    // assign it then keep its value, and no latch is inferred.
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TCW'(1);
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = to_cnt_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      tick_cnt_d = tick_cnt_q;
      samp_d     = '0;
      bit_d      = '0;
      shadow_d   = '0;
      byte_cnt_d = '0;
      to_cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_sync_q) begin
            // Start detect re-phases the tick. It also outranks a timeout
            // that would fire on the same clock.
            state_d    = START;
            samp_d     = '0;
            tick_cnt_d = '0;
            to_cnt_d   = '0;
          end else if (byte_cnt_q == 4'd0) begin
            to_cnt_d = '0;
          end else if (tick) begin
            if (to_cnt_q == TOW'(TO_TICKS - 1)) begin
              timeout_d  = 1'b1;
              shadow_d   = '0;
              byte_cnt_d = '0;
              to_cnt_d   = '0;
            end else begin
              to_cnt_d = to_cnt_q + TOW'(1);
            end
          end
        end
        START: begin
          if (tick) begin
            if (samp_q == 4'd7) begin
              samp_d = '0;
              bit_d  = '0;
              state_d = rx_sync_q ? IDLE : DATA;
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd15) begin
              shift_d = {rx_sync_q, shift_q[7:1]};
              if (bit_q == 3'd7) state_d = STOP;
              else               bit_d   = bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd15) begin
              if (rx_sync_q) begin
                state_d = IDLE;
                if (byte_cnt_q == 4'(NUM_BYTES - 1)) begin
                  data_d     = merged;
                  valid_d    = 1'b1;
                  shadow_d   = '0;
                  byte_cnt_d = '0;
                end else begin
                  shadow_d   = merged;
                  byte_cnt_d = byte_cnt_q + 4'd1;
                end
              end else begin
                state_d     = BREAK;
                frame_err_d = 1'b1;
                shadow_d    = '0;
                byte_cnt_d  = '0;
              end
            end
          end
        end
        BREAK: begin
          // Only one frame error is reported for a line held low.
          if (rx_sync_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments, so
  // every flop samples its input from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign timeout_o   = timeout_q;
  assign byte_cnt_o  = byte_cnt_q;
  assign busy_o      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word
//   Bench for uart_rx_word with four instances:
//     line 0: NUM_BYTES=4,  MSB_FIRST=1 (main instance)
//     line 1: NUM_BYTES=4,  MSB_FIRST=0
//     line 2: NUM_BYTES=1
//     line 3: NUM_BYTES=16
//   Each instance has its own rx line. When a word is sent, its expected
//   value is pushed to that instance's queue. A monitor pops the queue and
//   compares on every valid_o pulse.
module tb_uart_rx_word;

  localparam int BIT_CLKS = 64;  // 16 * CLKS_PER_SAMPLE(4)

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [3:0]   rx_v;

  logic [31:0]  data0, data1;
  logic [7:0]   data2;
  logic [127:0] data3;
  logic [3:0]   valid, fe, to, busy;
  logic [3:0]   bc0, bc1, bc2, bc3;

  logic [127:0] q0[$], q1[$], q2[$], q3[$];
  int vcnt0 = 0, vcnt1 = 0, vcnt2 = 0, vcnt3 = 0;
  int fcnt0 = 0, tcnt0 = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_rx_word #(.CLKS_PER_SAMPLE(4), .NUM_BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_BITS(20)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx_v[0]), .data_o(data0), .valid_o(valid[0]),
    .frame_err_o(fe[0]), .timeout_o(to[0]), .byte_cnt_o(bc0), .busy_o(busy[0]));
  uart_rx_word #(.CLKS_PER_SAMPLE(4), .NUM_BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_BITS(20)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx_v[1]), .data_o(data1), .valid_o(valid[1]),
    .frame_err_o(fe[1]), .timeout_o(to[1]), .byte_cnt_o(bc1), .busy_o(busy[1]));
  uart_rx_word #(.CLKS_PER_SAMPLE(4), .NUM_BYTES(1), .MSB_FIRST(1'b1), .TIMEOUT_BITS(20)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx_v[2]), .data_o(data2), .valid_o(valid[2]),
    .frame_err_o(fe[2]), .timeout_o(to[2]), .byte_cnt_o(bc2), .busy_o(busy[2]));
  uart_rx_word #(.CLKS_PER_SAMPLE(4), .NUM_BYTES(16), .MSB_FIRST(1'b1), .TIMEOUT_BITS(20)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx_v[3]), .data_o(data3), .valid_o(valid[3]),
    .frame_err_o(fe[3]), .timeout_o(to[3]), .byte_cnt_o(bc3), .busy_o(busy[3]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors. They sample away from the active edge.
  always @(negedge clk) begin
    if (valid[0] | fe[0] | to[0])
      check("dut0_pulse_onehot", 128'(valid[0] + fe[0] + to[0]), 128'd1);
    if (fe[0]) fcnt0++;
    if (to[0]) tcnt0++;
    if (valid[0]) begin
      vcnt0++;
      if (q0.size() == 0) check("dut0_unexpected_valid", 128'd1, 128'd0);
      else                check("dut0_word", 128'(data0), q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valid[1] | fe[1] | to[1])
      check("dut1_pulse_onehot", 128'(valid[1] + fe[1] + to[1]), 128'd1);
    if (valid[1]) begin
      vcnt1++;
      if (q1.size() == 0) check("dut1_unexpected_valid", 128'd1, 128'd0);
      else                check("dut1_word", 128'(data1), q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valid[2] | fe[2] | to[2])
      check("dut2_pulse_onehot", 128'(valid[2] + fe[2] + to[2]), 128'd1);
    if (valid[2]) begin
      vcnt2++;
      if (q2.size() == 0) check("dut2_unexpected_valid", 128'd1, 128'd0);
      else                check("dut2_word", 128'(data2), q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valid[3] | fe[3] | to[3])
      check("dut3_pulse_onehot", 128'(valid[3] + fe[3] + to[3]), 128'd1);
    if (valid[3]) begin
      vcnt3++;
      if (q3.size() == 0) check("dut3_unexpected_valid", 128'd1, 128'd0);
      else                check("dut3_word", 128'(data3), q3.pop_front());
    end
  end

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input int ln, input logic [7:0] b, input logic stop_bit);
    rx_v[ln] = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_v[ln] = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_v[ln] = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx_v[ln] = 1'b1;
  endtask

  // w holds the word in transmission order: the first byte is at
  // w[8*nb-1 -: 8]. Line 1 receives it with the byte order reversed.
  task automatic send_word(input int ln, input int nb, input logic [127:0] w);
    logic [127:0] rev;
    rev = '0;
    for (int i = 0; i < nb; i++) rev[8*i +: 8] = w[8*(nb-1-i) +: 8];
    case (ln)
      0: q0.push_back(w);
      1: q1.push_back(rev);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    for (int i = 0; i < nb; i++) send_byte(ln, w[8*(nb-1-i) +: 8], 1'b1);
  endtask

  function automatic logic [127:0] rand_word(input int nb);
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    return w & ((128'd1 << (8 * nb)) - 128'd1);
  endfunction

  initial begin
    int v0;
    reset  = 1'b1;
    enable = 1'b1;
    rx_v   = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_data",     128'(data0),    128'd0);
    check("rst_valid",    128'(valid[0]), 128'd0);
    check("rst_frame",    128'(fe[0]),    128'd0);
    check("rst_timeout",  128'(to[0]),    128'd0);
    check("rst_byte_cnt", 128'(bc0),      128'd0);
    check("rst_busy",     128'(busy[0]),  128'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: basic word, both byte orders.
    send_word(0, 4, 128'hDEADBEEF);
    idle_bits(2);
    check("t1_valid_cnt", 128'(vcnt0), 128'd1);
    check("t1_byte_cnt",  128'(bc0),   128'd0);
    send_word(1, 4, 128'hDEADBEEF);
    idle_bits(2);
    check("t1_lsb_valid_cnt", 128'(vcnt1), 128'd1);

    // 2: 20-clk low glitch is rejected as a false start.
    rx_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_busy_in_glitch", 128'(busy[0]), 128'd1);
    repeat (10) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("t2_busy",      128'(busy[0]), 128'd0);
    check("t2_byte_cnt",  128'(bc0),     128'd0);
    check("t2_valid_cnt", 128'(vcnt0),   128'd1);
    check("t2_frame_cnt", 128'(fcnt0),   128'd0);

    // 3: framing error drops the partial word, and the next word is clean.
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    check("t3_byte_cnt_2", 128'(bc0), 128'd2);
    send_byte(0, 8'h33, 1'b0);
    idle_bits(2);
    check("t3_frame_cnt",   128'(fcnt0), 128'd1);
    check("t3_byte_cnt_0",  128'(bc0),   128'd0);
    check("t3_valid_cnt",   128'(vcnt0), 128'd1);
    send_word(0, 4, 128'h01020304);
    idle_bits(2);
    check("t3_valid_after", 128'(vcnt0), 128'd2);

    // 4: inter-byte timeout.
    send_byte(0, 8'h44, 1'b1);
    send_byte(0, 8'h55, 1'b1);
    idle_bits(19);
    check("t4_no_timeout_yet", 128'(tcnt0), 128'd0);
    check("t4_byte_cnt_held",  128'(bc0),   128'd2);
    idle_bits(2);
    check("t4_timeout_cnt",    128'(tcnt0), 128'd1);
    check("t4_byte_cnt_0",     128'(bc0),   128'd0);
    send_word(0, 4, 128'hCAFEBABE);
    idle_bits(2);
    check("t4_valid_after",    128'(vcnt0), 128'd3);

    // 5a: reset during byte 3 clears all outputs at once.
    send_byte(0, 8'hAB, 1'b1);
    send_byte(0, 8'hCD, 1'b1);
    fork
      send_byte(0, 8'hEF, 1'b1);
      begin
        repeat (300) @(negedge clk);
        check("t5_busy_before_rst", 128'(busy[0]), 128'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_data",     128'(data0), 128'd0);
        check("t5_rst_byte_cnt", 128'(bc0),   128'd0);
        check("t5_rst_busy",     128'(busy[0]), 128'd0);
        check("t5_rst_pulses",   128'({valid[0], fe[0], to[0]}), 128'd0);
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_bits(2);

    // 5b: dropping enable mid-word keeps data_o and drops the partial word.
    send_word(0, 4, 128'h11223344);
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    check("t5_byte_cnt_2", 128'(bc0), 128'd2);
    v0 = vcnt0;
    fork
      send_byte(0, 8'hCC, 1'b1);
      begin
        repeat (200) @(negedge clk);
        enable = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("t5_en_data_kept", 128'(data0),   128'h11223344);
    check("t5_en_byte_cnt",  128'(bc0),     128'd0);
    check("t5_en_busy",      128'(busy[0]), 128'd0);
    check("t5_en_no_valid",  128'(vcnt0),   128'(v0));
    enable = 1'b1;
    idle_bits(2);
    send_word(0, 4, 128'h55667788);
    idle_bits(2);
    check("t5_en_next_word", 128'(vcnt0), 128'(v0 + 1));

    // 6: three words back-to-back on each width.
    v0 = vcnt0;
    for (int k = 0; k < 3; k++) send_word(0, 4, rand_word(4));
    idle_bits(2);
    check("t6_n4_valid_cnt", 128'(vcnt0), 128'(v0 + 3));
    for (int k = 0; k < 3; k++) send_word(2, 1, rand_word(1));
    idle_bits(2);
    check("t6_n1_valid_cnt", 128'(vcnt2), 128'd3);
    for (int k = 0; k < 3; k++) send_word(3, 16, rand_word(16));
    idle_bits(2);
    check("t6_n16_valid_cnt", 128'(vcnt3), 128'd3);

    // Final state: every queued word was seen, and the error counts are exact.
    check("end_q0_empty",   128'(q0.size()), 128'd0);
    check("end_q1_empty",   128'(q1.size()), 128'd0);
    check("end_q2_empty",   128'(q2.size()), 128'd0);
    check("end_q3_empty",   128'(q3.size()), 128'd0);
    check("end_frame_cnt",  128'(fcnt0),     128'd1);
    check("end_timeout_cnt",128'(tcnt0),     128'd1);
    check("end_idle_others",128'({bc1, bc2, bc3, busy[3:1]}), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
